instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have the following ports, in this order (name  direction  width  meaning):
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 start  in  1  pulse: load write address from base_addr, clear instr_count, arm the encoder.
REQ-005 base_addr  in  32  byte address of the first instruction word; bits [1:0] are forced to 0.
REQ-006 in_valid / in_ready  in / out  1 / 1  instruction-field handshake; a transfer occurs when both are 1 at a rising edge.
REQ-007 op_sel  in  3  instruction class: 0 LW, 1 SW, 2 R-type, 3 I-type ALU, 4 BEQ, 5 JAL, 6-7 illegal.
REQ-008 alu_sel  in  3  ALU function for R/I-type: 000 ADD, 001 SUB (R only), 101 SLT, 010 OR, 011 AND.
REQ-009 rd, rs1, rs2  in  5 each  register indices.
REQ-010 imm  in  32  signed byte immediate or offset.
REQ-011 mem_req  out  1  instruction-memory write request.
REQ-012 mem_addr / mem_wdata  out  32 / 32  write address and encoded instruction word.
REQ-013 mem_ack  in  1  memory accepts the write in any cycle it is high while mem_req is high.
REQ-014 instr_count  out  16  words written since the last start.
REQ-015 err  out  1  sticky: set when an input was rejected.
REQ-016 busy  out  1  high in WRITE.

Function
REQ-017 The FSM SHALL have three states: IDLE, ACCEPT and WRITE.
REQ-018 IDLE: the FSM SHALL go to ACCEPT on start.
REQ-019 ACCEPT: in_ready SHALL equal ~start.
REQ-020 WRITE: the FSM SHALL go to ACCEPT on the edge where mem_req and mem_ack are both high.
REQ-021 A legal transfer at edge N SHALL register the encoded word, and mem_req SHALL be high from cycle N+1 until the ack edge, with mem_addr and mem_wdata held stable.
REQ-022 On the ack edge, mem_addr SHALL advance by 4 (wrapping modulo 2^32) and instr_count SHALL increment (saturating at 0xFFFF).
REQ-023 A zero-wait ack SHALL give one word per 2 cycles.
REQ-024 Opcodes SHALL be: LW 0000011, SW 0100011, R 0110011, I 0010011, BEQ 1100011, JAL 1101111.
REQ-025 funct3 SHALL be: LW/SW 010, BEQ 000, ADD/SUB 000, SLT 010, OR 110, AND 111.
REQ-026 funct7 SHALL be 0100000 for SUB and 0000000 otherwise.
REQ-027 Immediate fields SHALL be placed per RV32I formats: I [31:20]=imm[11:0]; S [31:25]=imm[11:5] and [11:7]=imm[4:0]; B imm[12|10:5|4:1|11]; J imm[20|10:1|11|19:12].
REQ-028 Unused fields SHALL be 0: rd for SW/BEQ, rs2 for LW/I/JAL, rs1 for JAL.
REQ-029 Illegal op_sel, an illegal alu_sel, or SUB with op_sel=3 SHALL consume the transfer, set err, write nothing, and keep the FSM in ACCEPT.
REQ-030 start in ACCEPT SHALL reload mem_addr and clear instr_count; no transfer SHALL occur that cycle.
REQ-031 start in WRITE SHALL be ignored.
REQ-032 err SHALL clear only on reset or start.

Reset
REQ-033 While rst_n is low: state IDLE, in_ready 0, mem_req 0, busy 0, err 0, mem_addr 0, mem_wdata 0, instr_count 0.
REQ-034 Reset during WRITE SHALL drop mem_req immediately and abandon the pending write.
REQ-035 The first start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-036 With ENC_RANGE_CHECK_EN defined, an out-of-range immediate SHALL be rejected as in REQ-029. Legal ranges: I/S -2048..2047; B even, -4096..4094; J even, -1048576..1048574.
REQ-037 With ENC_RANGE_CHECK_EN undefined, the immediate SHALL be silently truncated to the field width, imm[0] SHALL be ignored for B/J, and err SHALL set only per REQ-029.

Verification
REQ-038 start with base_addr 0x100, then R ADD rd3 rs1=1 rs2=2 -> mem_wdata 0x002081B3 at mem_addr 0x100; instr_count 1.
REQ-039 Back-to-back SUB x3,x1,x2; LW x5,8(x2); SW x5,12(x2) with mem_ack held high -> 0x402081B3, 0x00812283, 0x00512623 at 0x100/0x104/0x108, one word every 2 cycles.
REQ-040 BEQ x1,x2,-8 then JAL x1,16 with mem_ack delayed 3 cycles -> 0xFE208CE3, 0x010000EF; mem_req and data stable while waiting.
REQ-041 op_sel=6 -> err=1, no mem_req, in_ready stays 1; next start clears err.
REQ-042 I-type ADDI with imm=4096 -> with ENC_RANGE_CHECK_EN: err=1, no write; without it: immediate field 0x000 written.
REQ-043 rst_n low during WRITE -> mem_req 0 asynchronously, instr_count 0; base_addr 0xFFFFFFFC wraps mem_addr to 0x0 after one write.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs op/alu/register/immediate fields into a word and writes it to sequential addresses.
// Latency: word registered on the accepting edge, mem_req from the next cycle until ack (2 cycles/word at zero wait).
// Backpressure: in_ready only in ACCEPT without start; mem_req/addr/data held until mem_ack. Optional ENC_RANGE_CHECK_EN.
module instr_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  op_sel,
    input  logic [2:0]  alu_sel,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    output logic [15:0] instr_count,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE} state_t;

    state_t      state, state_nxt;
    logic [31:0] enc_word;
    logic        enc_ok;
    logic        alu_ok;
    logic [2:0]  f3_alu;
    logic [6:0]  f7_alu;

`ifdef ENC_RANGE_CHECK_EN
    logic i_fits, b_fits, j_fits;
    assign i_fits = (&imm[31:11]) | ~(|imm[31:11]);
    assign b_fits = ((&imm[31:12]) | ~(|imm[31:12])) & ~imm[0];
    assign j_fits = ((&imm[31:20]) | ~(|imm[31:20])) & ~imm[0];
`else
    // Upper immediate bits are truncated away when range checking is off.
    logic unused_imm_hi;
    assign unused_imm_hi = ^imm[31:21];
`endif

    always_comb begin
        alu_ok = 1'b1;
        f3_alu = 3'b000;
        f7_alu = 7'b0000000;
        case (alu_sel)
            3'b000: f3_alu = 3'b000;
            3'b001: f7_alu = 7'b0100000;
            3'b101: f3_alu = 3'b010;
            3'b010: f3_alu = 3'b110;
            3'b011: f3_alu = 3'b111;
            default: alu_ok = 1'b0;
        endcase
    end

    always_comb begin
        enc_ok   = 1'b1;
        enc_word = '0;
        case (op_sel)
            3'd0: begin
                enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
`ifdef ENC_RANGE_CHECK_EN
                enc_ok = i_fits;
`endif
            end
            3'd1: begin
                enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
`ifdef ENC_RANGE_CHECK_EN
                enc_ok = i_fits;
`endif
            end
            3'd2: begin
                enc_word = {f7_alu, rs2, rs1, f3_alu, rd, 7'b0110011};
                enc_ok   = alu_ok;
            end
            3'd3: begin
                // No SUBI in RV32I: alu_sel 001 is illegal for immediates.
                enc_word = {imm[11:0], rs1, f3_alu, rd, 7'b0010011};
                enc_ok   = alu_ok && (alu_sel != 3'b001);
`ifdef ENC_RANGE_CHECK_EN
                enc_ok = enc_ok && i_fits;
`endif
            end
            3'd4: begin
                enc_word = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
`ifdef ENC_RANGE_CHECK_EN
                enc_ok = b_fits;
`endif
            end
            3'd5: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
`ifdef ENC_RANGE_CHECK_EN
                enc_ok = j_fits;
`endif
            end
            default: enc_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCEPT;
            ACCEPT:  if (!start && in_valid && enc_ok) state_nxt = WRITE;
            WRITE:   if (mem_ack) state_nxt = ACCEPT;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == ACCEPT) && !start;
    assign mem_req  = (state == WRITE);
    assign busy     = (state == WRITE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            instr_count <= '0;
            err         <= 1'b0;
        end else if (state == WRITE) begin
            if (mem_ack) begin
                mem_addr <= mem_addr + 32'd4;
                if (instr_count != 16'hFFFF) instr_count <= instr_count + 16'd1;
            end
        end else if (start) begin
            mem_addr    <= {base_addr[31:2], 2'b00};
            instr_count <= '0;
            err         <= 1'b0;
        end else if (state == ACCEPT && in_valid) begin
            if (enc_ok) mem_wdata <= enc_word;
            else        err       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected {addr, word} pushed on accepted transfers, popped on write acks.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op_sel = '0;
    logic [2:0]  alu_sel = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        mem_req;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] instr_count;
    logic        err, busy;

    instr_encoder dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel), .alu_sel(alu_sel),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .instr_count(instr_count), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cyc      = 0;
    int          ack_delay = 0;
    int          wcnt     = 0;
    logic [63:0] sb[$];
    int          ack_cyc[$];
    logic [31:0] exp_addr = '0;
    int          exp_cnt  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory model: ack after ack_delay cycles of mem_req.
    always @(posedge clk) begin
        #1;
        if (!mem_req) begin
            wcnt    = 0;
            mem_ack = 1'b0;
        end else begin
            mem_ack = (wcnt >= ack_delay);
            wcnt++;
        end
    end

    logic [31:0] hold_a, hold_d;
    bit          holding = 0;
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst_n || !mem_req) holding = 0;
        else begin
            if (holding) begin
                check_val("addr_stable", mem_addr, hold_a);
                check_val("data_stable", mem_wdata, hold_d);
            end else begin
                holding = 1;
                hold_a  = mem_addr;
                hold_d  = mem_wdata;
            end
            if (mem_ack) begin
                holding = 0;
                ack_cyc.push_back(cyc);
                if (sb.size() == 0) check_val("sb_underflow", 32'd1, 32'd0);
                else begin
                    e = sb.pop_front();
                    check_val("wr_addr", mem_addr, e[63:32]);
                    check_val("wr_data", mem_wdata, e[31:0]);
                end
            end
        end
    end

    // Reference encoder built from shifted fields.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [2:0] alu,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [31:0] im,
                                          output bit ok);
        logic [31:0] f3, f7, w;
        int si;
        ok = 1; f3 = 0; f7 = 0; w = 0; si = $signed(im);
        if (op == 3'd2 || op == 3'd3) begin
            case (alu)
                3'd0: f3 = 32'd0;
                3'd1: begin f7 = 32'd32; ok = (op == 3'd2); end
                3'd5: f3 = 32'd2;
                3'd2: f3 = 32'd6;
                3'd3: f3 = 32'd7;
                default: ok = 0;
            endcase
        end
        case (op)
            3'd0, 3'd3: begin
                w = ((im & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7);
                w = w | ((op == 3'd0) ? ((32'd2 << 12) | 32'h03) : ((f3 << 12) | 32'h13));
`ifdef ENC_RANGE_CHECK_EN
                if (si < -2048 || si > 2047) ok = 0;
`endif
            end
            3'd1: begin
                w = (((im >> 5) & 32'h7F) << 25) | (32'(s2) << 20) | (32'(s1) << 15)
                    | (32'd2 << 12) | ((im & 32'h1F) << 7) | 32'h23;
`ifdef ENC_RANGE_CHECK_EN
                if (si < -2048 || si > 2047) ok = 0;
`endif
            end
            3'd2: w = (f7 << 25) | (32'(s2) << 20) | (32'(s1) << 15) | (f3 << 12) | (32'(d) << 7) | 32'h33;
            3'd4: begin
                w = (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(s2) << 20)
                    | (32'(s1) << 15) | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | 32'h63;
`ifdef ENC_RANGE_CHECK_EN
                if (si < -4096 || si > 4094 || im[0]) ok = 0;
`endif
            end
            3'd5: begin
                w = (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                    | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | (32'(d) << 7) | 32'h6F;
`ifdef ENC_RANGE_CHECK_EN
                if (si < -1048576 || si > 1048574 || im[0]) ok = 0;
`endif
            end
            default: ok = 0;
        endcase
        if (!ok) w = 0;
        return w;
    endfunction

    task automatic send(input logic [2:0] op, input logic [2:0] alu, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                        input bit legal, input logic [31:0] word);
        bit done = 0;
        op_sel = op; alu_sel = alu; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (in_ready) done = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!done) check_val("handshake_timeout", 32'd0, 32'd1);
        else if (legal) begin
            sb.push_back({exp_addr, word});
            exp_addr += 32'd4;
            exp_cnt++;
        end
    endtask

    task automatic do_start(input logic [31:0] base);
        start = 1'b1; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = {base[31:2], 2'b00};
        exp_cnt  = 0;
    endtask

    task automatic drain;
        for (int i = 0; i < 300 && (sb.size() != 0 || mem_req); i++) @(posedge clk);
        #1;
        check_val("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] w;
        bit ok;
        logic [2:0] alus[5] = '{3'd0, 3'd1, 3'd5, 3'd2, 3'd3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_mem_req", 32'(mem_req), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        check_val("rst_mem_wdata", mem_wdata, 32'd0);
        check_val("rst_instr_count", 32'(instr_count), 32'd0);

        // First start right after reset release.
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_start(32'h100);
        @(negedge clk);
        check_val("first_start_ready", 32'(in_ready), 32'd1);
        check_val("start_addr", mem_addr, 32'h100);
        @(posedge clk); #1;

        send(3'd2, 3'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h002081B3);
        drain();
        check_val("count_after_add", 32'(instr_count), 32'd1);

        // Back-to-back, zero-wait ack.
        do_start(32'h100);
        ack_cyc.delete();
        send(3'd2, 3'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1, 32'h402081B3);
        send(3'd0, 3'd0, 5'd5, 5'd2, 5'd0, 32'd8, 1, 32'h00812283);
        send(3'd1, 3'd0, 5'd0, 5'd2, 5'd5, 32'd12, 1, 32'h00512623);
        drain();
        check_val("b2b_acks", 32'(ack_cyc.size()), 32'd3);
        if (ack_cyc.size() == 3) begin
            check_val("b2b_gap1", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
            check_val("b2b_gap2", 32'(ack_cyc[2] - ack_cyc[1]), 32'd2);
        end
        check_val("count_b2b", 32'(instr_count), 32'd3);

        // Delayed ack, data held stable.
        ack_delay = 3;
        send(3'd4, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1, 32'hFE208CE3);
        send(3'd5, 3'd0, 5'd1, 5'd0, 5'd0, 32'd16, 1, 32'h010000EF);
        drain();
        check_val("count_delayed", 32'(instr_count), 32'd5);
        ack_delay = 0;

        // Illegal inputs are consumed and flagged.
        send(3'd6, 3'd0, 5'd1, 5'd1, 5'd1, 32'd0, 0, 32'd0);
        check_val("illegal_err", 32'(err), 32'd1);
        check_val("illegal_no_req", 32'(mem_req), 32'd0);
        check_val("illegal_ready", 32'(in_ready), 32'd1);
        do_start(32'h200);
        check_val("start_clears_err", 32'(err), 32'd0);
        send(3'd3, 3'd1, 5'd1, 5'd1, 5'd1, 32'd1, 0, 32'd0);
        check_val("subi_err", 32'(err), 32'd1);
        do_start(32'h200);
        send(3'd2, 3'd4, 5'd1, 5'd1, 5'd1, 32'd0, 0, 32'd0);
        check_val("bad_alu_err", 32'(err), 32'd1);
        check_val("bad_alu_count", 32'(instr_count), 32'd0);
        do_start(32'h200);

        // ADDI x1, x2, 4096
`ifdef ENC_RANGE_CHECK_EN
        send(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 32'd4096, 0, 32'd0);
        check_val("range_err", 32'(err), 32'd1);
        check_val("range_no_req", 32'(mem_req), 32'd0);
`else
        send(3'd3, 3'd0, 5'd1, 5'd2, 5'd0, 32'd4096, 1, 32'h00010093);
        drain();
        check_val("trunc_no_err", 32'(err), 32'd0);
`endif
        do_start(32'h1000);

        for (int i = 0; i < 24; i++) begin
            logic [2:0] op, alu;
            logic [4:0] d, s1, s2;
            logic [31:0] im;
            op = 3'($urandom_range(0, 7));
            alu = alus[$urandom_range(0, 4)];
            d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
            im = (i % 3 == 0) ? $urandom : 32'($urandom_range(0, 8191)) - 32'd4096;
            ack_delay = $urandom_range(0, 2);
            w = model(op, alu, d, s1, s2, im, ok);
            send(op, alu, d, s1, s2, im, ok, w);
        end
        drain();
        check_val("count_random", 32'(instr_count), 32'(exp_cnt));

        // start while writing is ignored.
        ack_delay = 4;
        send(3'd2, 3'd2, 5'd7, 5'd8, 5'd9, 32'd0, 1, model(3'd2, 3'd2, 5'd7, 5'd8, 5'd9, 32'd0, ok));
        start = 1'b1; base_addr = 32'h800;
        @(posedge clk); #1;
        start = 1'b0;
        check_val("start_in_write_busy", 32'(busy), 32'd1);
        check_val("start_in_write_addr", mem_addr, exp_addr - 32'd4);
        drain();
        check_val("start_in_write_count", 32'(instr_count), 32'(exp_cnt));

        // Reset in the middle of a pending write.
        ack_delay = 50;
        send(3'd5, 3'd0, 5'd2, 5'd0, 5'd0, 32'd64, 1, 32'h0400016F);
        @(posedge clk); #2;
        check_val("pre_rst_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_drops_req", 32'(mem_req), 32'd0);
        check_val("rst_count", 32'(instr_count), 32'd0);
        check_val("rst_busy_mid", 32'(busy), 32'd0);
        sb.delete();
        ack_delay = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Address wrap; low base bits are ignored.
        do_start(32'hFFFFFFFF);
        send(3'd2, 3'd3, 5'd4, 5'd5, 5'd6, 32'd0, 1, 32'h0062F233);
        drain();
        check_val("wrap_addr", mem_addr, 32'h0);
        check_val("wrap_count", 32'(instr_count), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
